dmem_bytelane: RTL and testbench

Byte-addressed RV32I data memory with per-byte write enables and load/store size/sign handling (LB/LH/LW/LBU/LHU/SB/SH/SW). It sits in the MEM stage of the pipeline, behind the ALU address result, and replaces the word-indexed combinational-read memory. Reads are synchronous with one-cycle latency. Misaligned and out-of-range accesses are flagged. After reset, the block clears itself with a hardware sweep before it accepts any request.

---
 rtl/rv32_pkg.sv | 19 +
 rtl/byte_lane_ram.sv | 25 ++
 rtl/dmem_bytelane.sv | 168 ++++++++++++++++
 tb/tb_dmem_bytelane.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I load/store funct3 encodings and the data-memory controller state type.
package rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/byte_lane_ram.sv
// DEPTH_WORDS x 32 storage with per-byte write enables and a registered read port.
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed RV32I data memory: size/sign handling, fault checks, and a
// post-reset zero sweep that must finish before requests are accepted.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_CLEAR | writing zero to word cnt_q each cycle; requests ignored
//   ST_RUN   | normal operation, one request per cycle
module dmem_bytelane
  import rv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == ST_RUN) && !rst;

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             oor, misal, illegal, fault;
  logic [3:0]       be;
  logic [31:0]      wd;

  assign accept = req_valid && ready;
  assign idx    = req_addr[IDX_W+1:2];
  assign off    = req_addr[1:0];
  // Any bit above the word index set means the access would alias; fault it instead.
  assign oor    = (req_addr >> (IDX_W + 2)) != '0;

  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    be      = 4'b0000;
    wd      = req_wdata;
    if (req_we) begin
      case (req_funct3)
        F3_SB: begin
          be = 4'b0001 << off;
          wd = {4{req_wdata[7:0]}};
        end
        F3_SH: begin
          be    = off[1] ? 4'b1100 : 4'b0011;
          wd    = {2{req_wdata[15:0]}};
          misal = off[0];
        end
        F3_SW: begin
          be    = 4'b1111;
          misal = (off != 2'b00);
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        F3_LB, F3_LBU: misal = 1'b0;
        F3_LH, F3_LHU: misal = off[0];
        F3_LW:         misal = (off != 2'b00);
        default:       illegal = 1'b1;
      endcase
    end
  end

  assign fault = illegal || misal || oor;

  logic             clearing;
  logic [3:0]       ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  assign clearing  = (state_q == ST_CLEAR) && !rst;
  assign ram_we    = clearing ? 4'b1111 :
                     (accept && req_we && !fault) ? be : 4'b0000;
  assign ram_waddr = clearing ? cnt_q : idx;
  assign ram_wdata = clearing ? 32'h0 : wd;

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  logic       valid_q, fault_q, load_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      load_q  <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      valid_q <= accept;
      fault_q <= accept && fault;
      load_q  <= accept && !req_we && !fault;
      f3_q    <= req_funct3;
      off_q   <= off;
    end
  end

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext;

  always_comb begin
    case (off_q)
      2'd0:    sel_byte = ram_rdata[7:0];
      2'd1:    sel_byte = ram_rdata[15:8];
      2'd2:    sel_byte = ram_rdata[23:16];
      default: sel_byte = ram_rdata[31:24];
    endcase
    sel_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (f3_q)
      F3_LB:   ext = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  ext = {24'h0, sel_byte};
      F3_LH:   ext = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  ext = {16'h0, sel_half};
      default: ext = ram_rdata;
    endcase
  end

  assign rsp_valid = valid_q;
  assign rsp_fault = fault_q;
  assign rsp_rdata = load_q ? ext : 32'h0;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane with DEPTH_WORDS = 16.
module tb_dmem_bytelane;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        ready, rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;

  dmem_bytelane #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ready      (ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every response cycle pops one expectation; idle cycles must show zeros.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rsp_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got rdata=%h fault=%b with nothing pending", rsp_rdata, rsp_fault);
          end else begin
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata || rsp_fault !== e.fault) begin
              errors++;
              $display("FAIL rsp: got rdata=%h fault=%b expected rdata=%h fault=%b",
                       rsp_rdata, rsp_fault, e.rdata, e.fault);
            end
          end
        end else begin
          checks++;
          if (rsp_rdata !== 32'h0 || rsp_fault !== 1'b0) begin
            errors++;
            $display("FAIL idle_zero: got rdata=%h fault=%b expected 0/0", rsp_rdata, rsp_fault);
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ef);
    exp_t e;
    e.rdata = er;
    e.fault = ef;
    exp_q.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Counts edges from the first rst-low cycle until ready; offers a store to
  // word 0 while not ready, which must be ignored.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      req_valid  = (n >= 2 && n < 14);
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0;
      req_wdata  = 32'hDEADBEEF;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_fault", {31'h0, rsp_fault}, 32'h0);
    mon_en = 1'b1;
    rst = 1'b0;
    wait_ready(n);
    chk("clear_cycles", n, DEPTH);

    for (int a = 0; a < 4 * DEPTH; a += 4) issue(1'b0, 3'b010, a, 32'h0, 32'h0, 1'b0);

    // SW then back-to-back sized loads
    issue(1'b1, 3'b010, 32'h8, 32'h8001FF7F, 32'h0, 1'b0);
    issue(1'b0, 3'b000, 32'h8, 32'h0, 32'h0000007F, 1'b0);
    issue(1'b0, 3'b100, 32'h8, 32'h0, 32'h0000007F, 1'b0);
    issue(1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFF8001, 1'b0);
    issue(1'b0, 3'b101, 32'hA, 32'h0, 32'h00008001, 1'b0);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'h8001FF7F, 1'b0);
    issue(1'b0, 3'b000, 32'hB, 32'h0, 32'hFFFFFF80, 1'b0);
    issue(1'b0, 3'b100, 32'hB, 32'h0, 32'h00000080, 1'b0);
    issue(1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFFFFFF, 1'b0);
    idle(2);

    // SB / SH into word 1, neighbours untouched
    issue(1'b1, 3'b000, 32'h5, 32'hFFFFFFAB, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'h6, 32'hFFFF1234, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 32'h1234AB00, 1'b0);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h00000000, 1'b0);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'h8001FF7F, 1'b0);
    issue(1'b0, 3'b101, 32'h6, 32'h0, 32'h00001234, 1'b0);

    // Faults and boundaries
    issue(1'b1, 3'b010, 32'h2, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h00000000, 1'b0);
    issue(1'b0, 3'b001, 32'h3, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h80000000, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'b010, 32'h3C, 32'hCAFEF00D, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h3C, 32'h0, 32'hCAFEF00D, 1'b0);
    issue(1'b1, 3'b010, 32'h40, 32'h11111111, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h00000000, 1'b0);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b110, 32'h8, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'b100, 32'h8, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'h8001FF7F, 1'b0);
    drain();

    // Reset during a store's response cycle; a store offered alongside rst is dropped
    issue(1'b1, 3'b010, 32'h10, 32'h55AA55AA, 32'h0, 1'b0);
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h14;
    req_wdata  = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_pending", exp_q.size(), 0);
    rst = 1'b0;
    wait_ready(n);
    chk("reclear_cycles", n, DEPTH);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h00000000, 1'b0);
    issue(1'b0, 3'b010, 32'h14, 32'h0, 32'h00000000, 1'b0);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'h00000000, 1'b0);
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
